// File: rtl/key_debounce_n.sv
// rtl/key_debounce_n.sv - multi-channel key debouncer with press/release/long/repeat pulses
//
// Purpose: per-key 2-flop synchronizer, 1 ms tick based debounce, long-press
// detection and auto-repeat. All outputs registered.
//
// Ports:
//   sys_clk      - single clock, rising edge
//   sys_rst      - synchronous active-high reset
//   key_in       - raw asynchronous key levels (N_KEYS)
//   key_state    - debounced pressed level, 1 = pressed
//   key_press    - one-cycle pulse when key_state rises
//   key_release  - one-cycle pulse when key_state falls
//   key_long     - one-cycle pulse once per press after LONG_MS held
//   key_repeat   - one-cycle pulse every REPEAT_MS after key_long while held
//   key_any      - OR of key_state
`timescale 1ns/1ps

module key_debounce_n #(
    parameter int N_KEYS      = 4,
    parameter int CLK_FREQ    = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000,
    parameter int REPEAT_MS   = 100,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              key_any
);

    localparam int TICK_MAX = CLK_FREQ / 1000 - 1;
    localparam int TICK_W   = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
    localparam int DB_W     = (DEBOUNCE_MS < 2) ? 1 : $clog2(DEBOUNCE_MS);
    localparam int HOLD_W   = $clog2(LONG_MS + 1);
    localparam int REP_W    = (REPEAT_MS < 2) ? 1 : $clog2(REPEAT_MS);
    localparam int REP_LAST = (REPEAT_MS > 0) ? REPEAT_MS - 1 : 0;

    // Raw level of an idle (released) key; synchronizers reset to this.
    localparam logic [N_KEYS-1:0] RELEASED = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] pressed;

    logic [N_KEYS-1:0] state_q, state_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] release_q, release_d;
    logic [N_KEYS-1:0] long_q, long_d;
    logic [N_KEYS-1:0] repeat_q, repeat_d;

    logic [DB_W-1:0]   db_cnt_q [N_KEYS];
    logic [DB_W-1:0]   db_cnt_d [N_KEYS];
    logic [HOLD_W-1:0] hold_q   [N_KEYS];
    logic [HOLD_W-1:0] hold_d   [N_KEYS];
    logic [REP_W-1:0]  rep_q    [N_KEYS];
    logic [REP_W-1:0]  rep_d    [N_KEYS];

    assign tick       = (tick_cnt_q == TICK_W'(TICK_MAX));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);

    // XOR with the idle level turns the synchronized raw level into "pressed".
    assign pressed = sync2_q ^ RELEASED;

    always_comb begin
        state_d   = state_q;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        repeat_d  = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            db_cnt_d[k] = db_cnt_q[k];
            hold_d[k]   = hold_q[k];
            rep_d[k]    = rep_q[k];

            if (tick) begin
                if (pressed[k] == state_q[k]) begin
                    db_cnt_d[k] = '0;
                end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_MS - 1)) begin
                    state_d[k]   = ~state_q[k];
                    db_cnt_d[k]  = '0;
                    press_d[k]   = ~state_q[k];
                    release_d[k] = state_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
                end
            end

            // Using the next state clears hold/repeat on the release edge itself.
            if (!state_d[k]) begin
                hold_d[k] = '0;
                rep_d[k]  = '0;
            end else if (tick && state_q[k]) begin
                if (hold_q[k] == HOLD_W'(LONG_MS)) begin
                    // Saturated: long already fired, run the repeat period.
                    if (REPEAT_MS > 0) begin
                        if (rep_q[k] == REP_W'(REP_LAST)) begin
                            rep_d[k]    = '0;
                            repeat_d[k] = 1'b1;
                        end else begin
                            rep_d[k] = rep_q[k] + REP_W'(1);
                        end
                    end
                end else begin
                    hold_d[k] = hold_q[k] + HOLD_W'(1);
                    if (hold_q[k] == HOLD_W'(LONG_MS - 1)) begin
                        long_d[k] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt_q <= '0;
            sync1_q    <= RELEASED;
            sync2_q    <= RELEASED;
            state_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            long_q     <= '0;
            repeat_q   <= '0;
            for (int k = 0; k < N_KEYS; k++) begin
                db_cnt_q[k] <= '0;
                hold_q[k]   <= '0;
                rep_q[k]    <= '0;
            end
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync1_q    <= key_in;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            repeat_q   <= repeat_d;
            for (int k = 0; k < N_KEYS; k++) begin
                db_cnt_q[k] <= db_cnt_d[k];
                hold_q[k]   <= hold_d[k];
                rep_q[k]    <= rep_d[k];
            end
        end
    end

    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;
    assign key_any     = |state_q;

endmodule

// File: tb/tb_key_debounce_n.sv
// tb/tb_key_debounce_n.sv - self-checking bench for key_debounce_n
`timescale 1ns/1ps

module tb_key_debounce_n;

    localparam int NK   = 4;
    localparam int CPT  = 50;   // clock cycles per 1 ms tick
    localparam int DB   = 4;
    localparam int LONG = 20;
    localparam int REP  = 5;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [NK-1:0] key_in  = '1;

    logic [NK-1:0] state_a, press_a, rel_a, long_a, rep_a;
    logic          any_a;
    logic [NK-1:0] state_b, press_b, rel_b, long_b, rep_b;
    logic          any_b;

    key_debounce_n #(
        .N_KEYS(NK), .CLK_FREQ(50_000), .DEBOUNCE_MS(DB),
        .LONG_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(1)
    ) dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
        .key_state(state_a), .key_press(press_a), .key_release(rel_a),
        .key_long(long_a), .key_repeat(rep_a), .key_any(any_a)
    );

    key_debounce_n #(
        .N_KEYS(NK), .CLK_FREQ(50_000), .DEBOUNCE_MS(DB),
        .LONG_MS(LONG), .REPEAT_MS(0), .ACTIVE_LOW(1)
    ) dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .key_in(key_in),
        .key_state(state_b), .key_press(press_b), .key_release(rel_b),
        .key_long(long_b), .key_repeat(rep_b), .key_any(any_b)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rst_cyc = 0;

    // Reference model: raw-input delay line, per-key debounced level, count of
    // consecutive disagreeing ticks, and ticks held since the accepted press.
    int            m_edges;
    logic [NK-1:0] m_d1, m_d2;
    logic [NK-1:0] m_state, m_press, m_rel, m_long, m_rep;
    int            m_run  [NK];
    int            m_held [NK];

    int            press_t [NK][$];
    int            rel_t   [NK][$];
    int            long_t  [NK][$];
    int            rep_t   [NK][$];
    int            long2_t [NK][$];
    int            rep2_t  [NK][$];
    logic [NK-1:0] pv_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int first_tick_after(input int c);
        return rst_cyc + ((c - rst_cyc) / CPT + 1) * CPT;
    endfunction

    task automatic model_edge();
        bit was;
        bit samp;
        m_press = '0; m_rel = '0; m_long = '0; m_rep = '0;
        if (sys_rst) begin
            m_edges = 0;
            m_d1 = '1; m_d2 = '1; m_state = '0;
            for (int k = 0; k < NK; k++) begin
                m_run[k] = 0; m_held[k] = 0;
            end
        end else begin
            m_edges++;
            if (m_edges % CPT == 0) begin
                for (int k = 0; k < NK; k++) begin
                    samp = !m_d2[k];
                    was  = m_state[k];
                    if (samp == was) m_run[k] = 0;
                    else begin
                        m_run[k]++;
                        if (m_run[k] == DB) begin
                            m_state[k] = !was;
                            m_run[k]   = 0;
                            m_held[k]  = 0;
                            if (!was) m_press[k] = 1'b1;
                            else      m_rel[k]   = 1'b1;
                        end
                    end
                    if (was && m_state[k]) begin
                        m_held[k]++;
                        if (m_held[k] == LONG) m_long[k] = 1'b1;
                        if (m_held[k] > LONG && (m_held[k] - LONG) % REP == 0) m_rep[k] = 1'b1;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = key_in;
        end
    endtask

    task automatic clear_rec();
        for (int k = 0; k < NK; k++) begin
            press_t[k].delete(); rel_t[k].delete(); long_t[k].delete();
            rep_t[k].delete(); long2_t[k].delete(); rep2_t[k].delete();
        end
        pv_q.delete();
    endtask

    task automatic step();
        @(posedge sys_clk);
        cyc++;
        model_edge();
        #1;
        chk("cycle_dut_a", 32'({state_a, press_a, rel_a, long_a, rep_a, any_a}),
            32'({m_state, m_press, m_rel, m_long, m_rep, |m_state}));
        chk("cycle_dut_b_norepeat", 32'({state_b, press_b, rel_b, long_b, rep_b, any_b}),
            32'({m_state, m_press, m_rel, m_long, 4'b0000, |m_state}));
        for (int k = 0; k < NK; k++) begin
            if (press_a[k]) press_t[k].push_back(cyc);
            if (rel_a[k])   rel_t[k].push_back(cyc);
            if (long_a[k])  long_t[k].push_back(cyc);
            if (rep_a[k])   rep_t[k].push_back(cyc);
            if (long_b[k])  long2_t[k].push_back(cyc);
            if (rep_b[k])   rep2_t[k].push_back(cyc);
        end
        if (press_a != '0) pv_q.push_back(press_a);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int e0, t_exp, p, l, r, held, nrep;

        // Reset
        sys_rst = 1'b1;
        key_in  = '1;
        run(3);
        rst_cyc = cyc;
        chk("reset_outputs_a", 32'({state_a, press_a, rel_a, long_a, rep_a, any_a}), 32'd0);
        sys_rst = 1'b0;

        // Single press on key 0
        clear_rec();
        run($urandom_range(0, 49));
        e0 = cyc;
        key_in[0] = 1'b0;
        t_exp = first_tick_after(e0 + 2) + (DB - 1) * CPT;
        run(300);
        chk("k0_press_count", 32'(press_t[0].size()), 32'd1);
        chk("k0_press_time", 32'(at(press_t[0], 0)), 32'(t_exp));
        chk("k0_state", 32'(state_a[0]), 32'd1);
        chk("k0_any", 32'(any_a), 32'd1);
        key_in[0] = 1'b1;
        run(300);
        chk("k0_release_count", 32'(rel_t[0].size()), 32'd1);
        chk("k0_any_after_release", 32'(any_a), 32'd0);

        // 2 ms glitch on key 1
        clear_rec();
        run($urandom_range(0, 49));
        key_in[1] = 1'b0;
        run(2 * CPT);
        key_in[1] = 1'b1;
        run(400);
        chk("k1_glitch_press", 32'(press_t[1].size()), 32'd0);
        chk("k1_glitch_release", 32'(rel_t[1].size()), 32'd0);
        chk("k1_glitch_state", 32'(state_a[1]), 32'd0);

        // 40 ms hold on key 2: long, repeats, release
        clear_rec();
        run($urandom_range(0, 49));
        key_in[2] = 1'b0;
        run(40 * CPT);
        key_in[2] = 1'b1;
        run(400);
        p = at(press_t[2], 0);
        l = at(long_t[2], 0);
        r = at(rel_t[2], 0);
        chk("k2_press_count", 32'(press_t[2].size()), 32'd1);
        chk("k2_long_count", 32'(long_t[2].size()), 32'd1);
        chk("k2_long_offset", 32'(l - p), 32'(LONG * CPT));
        chk("k2_rep1_offset", 32'(at(rep_t[2], 0) - l), 32'(REP * CPT));
        chk("k2_rep2_offset", 32'(at(rep_t[2], 1) - l), 32'(2 * REP * CPT));
        chk("k2_rep3_offset", 32'(at(rep_t[2], 2) - l), 32'(3 * REP * CPT));
        held = (r - p) / CPT - 1;
        nrep = (held >= LONG) ? (held - LONG) / REP : 0;
        chk("k2_rep_count", 32'(rep_t[2].size()), 32'(nrep));
        chk("k2_release_count", 32'(rel_t[2].size()), 32'd1);
        chk("k2_no_rep_after_release", 32'(at(rep_t[2], rep_t[2].size() - 1) < r), 32'd1);
        chk("k2_norepeat_long_count", 32'(long2_t[2].size()), 32'd1);
        chk("k2_norepeat_rep_count", 32'(rep2_t[2].size()), 32'd0);

        // Keys 0 and 3 pressed together
        clear_rec();
        run($urandom_range(0, 49));
        key_in[0] = 1'b0;
        key_in[3] = 1'b0;
        run(300);
        chk("k03_press_events", 32'(pv_q.size()), 32'd1);
        chk("k03_press_vector", 32'((pv_q.size() > 0) ? pv_q[0] : 4'b0000), 32'b1001);
        key_in[0] = 1'b1;
        key_in[3] = 1'b1;
        run(300);
        chk("k03_both_released", 32'(state_a), 32'd0);

        // Reset while key 1 held past long
        clear_rec();
        key_in[1] = 1'b0;
        run(25 * CPT);
        chk("k1_long_before_reset", 32'(long_t[1].size()), 32'd1);
        sys_rst = 1'b1;
        step();
        rst_cyc = cyc;
        chk("k1_reset_outputs", 32'({state_a, press_a, rel_a, long_a, rep_a, any_a}), 32'd0);
        sys_rst = 1'b0;
        clear_rec();
        run(300);
        chk("k1_no_release_on_reset", 32'(rel_t[1].size()), 32'd0);
        chk("k1_repress_time", 32'(at(press_t[1], 0) - rst_cyc), 32'(DB * CPT));
        key_in[1] = 1'b1;
        run(300);

        // Random soak across all channels
        for (int i = 0; i < 40; i++) begin
            key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) key_in[$urandom_range(0, NK - 1)] ^= 1'b1;
            run($urandom_range(5, 600));
        end
        key_in = '1;
        run(400);
        chk("soak_all_released", 32'({state_a, any_a}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_debounce_n.md
KEY_DEBOUNCE_N -- requirements
Module: key_debounce_n

Interface
REQ-001 SHALL have parameter N_KEYS, default 4: number of independent key channels, range 1..16.
REQ-002 SHALL have parameter CLK_FREQ, default 50_000_000: sys_clk frequency in Hz; must be an integer multiple of 1000.
REQ-003 SHALL have parameter DEBOUNCE_MS, default 20: stable time required before accepting a level change, range 1..255.
REQ-004 SHALL have parameter LONG_MS, default 1000: hold time before the long-press pulse, range 1..65535.
REQ-005 SHALL have parameter REPEAT_MS, default 100: auto-repeat period after a long press; 0 disables repeat.
REQ-006 SHALL have parameter ACTIVE_LOW, default 1: when 1, key_in = 0 means pressed.
REQ-007 SHALL have port sys_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-008 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port key_in, input, N_KEYS bits: raw asynchronous key levels.
REQ-010 SHALL have port key_state, output, N_KEYS bits: debounced pressed level, 1 = pressed.
REQ-011 SHALL have port key_press, output, N_KEYS bits: one-cycle pulse per accepted press.
REQ-012 SHALL have port key_release, output, N_KEYS bits: one-cycle pulse per accepted release.
REQ-013 SHALL have port key_long, output, N_KEYS bits: one-cycle pulse once per press after LONG_MS held.
REQ-014 SHALL have port key_repeat, output, N_KEYS bits: one-cycle pulse every REPEAT_MS after key_long while held.
REQ-015 SHALL have port key_any, output, 1 bit: OR of key_state.

Function
REQ-016 SHALL generate an internal 1 ms tick: counter 0..CLK_FREQ/1000-1, tick high for one cycle when the count equals its maximum, then wrap to 0.
REQ-017 SHALL pass each key_in bit through a 2-flop synchronizer, then invert the result when ACTIVE_LOW=1 to form the pressed sample.
REQ-018 SHALL, per channel on each tick: clear the debounce counter if sample == key_state, otherwise increment it.
REQ-019 SHALL, when the counter already equals DEBOUNCE_MS-1 and the sample still differs on a tick, toggle key_state and clear the counter on that same edge.
REQ-020 SHALL reset the debounce counter on any tick where the sample returns to key_state, so glitches shorter than DEBOUNCE_MS ticks produce no output.
REQ-021 SHALL assert key_press (or key_release) on exactly the edge at which key_state rises (or falls), for one cycle, registered.
REQ-022 SHALL keep a per-channel hold counter, cleared while key_state=0, incremented on each tick while key_state=1, and saturating at LONG_MS.
REQ-023 SHALL pulse key_long for one cycle on the edge where the hold counter reaches LONG_MS, at most once per press.
REQ-024 SHALL, when REPEAT_MS>0 and after key_long, pulse key_repeat every REPEAT_MS ticks while held; first repeat REPEAT_MS ticks after key_long; the repeat counter wraps 0..REPEAT_MS-1.
REQ-025 SHALL, on release, clear hold and repeat counters on the same edge as key_release, with no further key_long or key_repeat pulses.
REQ-026 SHALL process channels independently: simultaneous events on several channels each produce their own pulses in the same cycle, with no priority and no masking.
REQ-027 SHALL register all outputs; key_any is derived from registered key_state with no added latency.
REQ-028 SHALL size every counter by $clog2 of its maximum value and never wrap the hold counter.

Reset
REQ-029 SHALL, while sys_rst=1 at a clock edge, clear key_state, all pulses, key_any, the tick counter, and all debounce, hold and repeat counters to 0, and load the synchronizers with the released level.
REQ-030 SHALL, on reset mid-press, emit no key_release; a key still held after reset SHALL re-debounce and emit a fresh key_press.

Verification
(Parameters: N_KEYS=4, CLK_FREQ=50_000 so 50 cycles/ms, DEBOUNCE_MS=4, LONG_MS=20, REPEAT_MS=5, ACTIVE_LOW=1.)
REQ-031 SHALL cover: key_in[0]=0 held -> key_state[0]=1 and one key_press[0] pulse on the 4th tick after the synchronized change; key_any=1.
REQ-032 SHALL cover: a 2 ms low glitch on key_in[1] -> no change on key_state, key_press or key_release.
REQ-033 SHALL cover: key_in[2] held 40 ms -> key_long[2] 20 ticks after key_press[2], then key_repeat[2] at +5, +10 and +15 ticks; release gives key_release[2] and no further pulses.
REQ-034 SHALL cover: keys 0 and 3 pressed in the same cycle -> key_press=4'b1001 in a single cycle.
REQ-035 SHALL cover: sys_rst pulsed while key 1 is held post-long -> all outputs 0 the next cycle, no release pulse, then key_press[1] 4 ticks after reset deasserts.
REQ-036 SHALL cover: REPEAT_MS=0 with a 40 ms hold -> exactly one key_long pulse and zero key_repeat pulses.
